spi_gpio_ctrl: RTL and testbench
================================

Name: spi_gpio_ctrl

Overview:
- Parametrised SPI-slave GPIO controller: successor to the 8-bit shift-register GPIO block.
- Runs on the system clock; SPI pins are synchronised internally and SCLK edges are detected from the synchronised copy.
- Supports WIDTH outputs with per-pin direction, atomic SET/CLR/TOGGLE, and read-back of pin inputs, output register or direction register on MISO.
- Sits between the board SPI master and the pad ring.

Parameters:
- WIDTH, 16: number of GPIO pins; multiple of 8, range 8..32.
- SYNC_STAGES, 2: synchroniser depth on sclk, cs_n and mosi; minimum 2.

Ports:
- clk  in  1  system clock; must be at least 4x the sclk frequency.
- rst  in  1  synchronous, active-high reset.
- sclk  in  1  SPI clock, asynchronous; mode 0 (CPOL=0, CPHA=0).
- cs_n  in  1  SPI chip select, active low, asynchronous.
- mosi  in  1  SPI data in, asynchronous.
- miso  out  1  SPI data out.
- miso_oe  out  1  MISO tristate enable.
- gpio_in  in  WIDTH  pad inputs; sampled in the clk domain.
- gpio_out  out  WIDTH  output register.
- gpio_oe  out  WIDTH  direction register; 1 = drive.
- frame_done  out  1  one-clk pulse per valid frame.

Behaviour:
- Clocking and reset (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values: gpio_out=0, gpio_oe=0, miso=0, miso_oe=0, frame_done=0, FSM=IDLE, bit counter=0. Synchroniser resets to sclk=0, cs_n=1, mosi=0.
- Synchronisation: sclk, cs_n and mosi each pass through SYNC_STAGES flops of equal depth.
- Edge detection: rise/fall are detected by comparing the last synchronised sclk stage with one extra delayed flop. mosi is sampled from its synchronised copy in the cycle a rise is detected.
- Frame format:
  - First 8 bits are the command byte, then WIDTH data bits, MSB first.
  - Command bit7: 1 = write, 0 = read. Bits[2:0] are the opcode; bits[6:3] are ignored.
  - Write opcodes:
    - 000: OUT=D.
    - 001: OUT|=D.
    - 010: OUT&=~D.
    - 011: OUT^=D.
    - 100: OE=D.
  - Read opcodes:
    - 000: return gpio_in.
    - 001: return OUT.
    - 100: return OE.
  - Any other opcode is an ILLEGAL command.
- FSM states:
  - IDLE -> CMD when synchronised cs_n falls.
  - CMD: shift mosi on each sclk rise; counter++. After the 8th rise -> DATA.
  - DATA: on entry with a read command, load the tx shift register with the selected value, captured in that clk cycle. counter++ on each rise, saturating at 8+WIDTH+1.
  - Synchronised cs_n rise in CMD or DATA -> IDLE, with the commit rules below.
- Commit:
  - Only when counter == 8+WIDTH exactly at cs_n rise and the command is not ILLEGAL.
  - Write: the register update and the frame_done pulse occur in the same clk cycle, one cycle after synchronised cs_n rise is detected.
  - Read: frame_done pulses; no register changes.
  - Short frame, long frame (counter saturated) or ILLEGAL command: no update, no frame_done.
- MISO:
  - miso_oe = synchronised cs_n low.
  - miso=0 during CMD and during write frames.
  - Read frames: tx MSB is driven on the clk after the sclk fall that follows the 8th rise. Shift left on each later sclk fall; 0 is shifted in.
  - miso=0 when cs_n is high.
- Mid-frame events:
  - Reset mid-frame: immediate return to reset values; the rest of the frame is ignored until the next cs_n fall.
  - cs_n fall while sclk is high: the frame starts, but the first detected fall is ignored.
- Simultaneous gpio_in change during the capture cycle: the value sampled in that cycle wins.
- Counter width: $clog2(8+WIDTH+2).

Test Plan (WIDTH=16):
- Reset, then write 0x80, data 0xA5C3 -> gpio_out=0xA5C3; one frame_done pulse; gpio_oe=0.
- OUT=0x00F0, then SET 0x0F00, CLR 0x0030, TGL 0x8001 -> gpio_out=0x0FC0 after SET/CLR, 0x8FC1 after TGL.
- Write 0x84 data 0xFFFF, then read 0x04 -> miso returns 0xFFFF MSB first; read 0x00 with gpio_in=0x1234 -> 0x1234; miso_oe high only while cs_n low.
- Frames of 23 and 25 bits with command 0x80 data 0xBEEF -> gpio_out unchanged; no frame_done. Command 0x87 -> no change.
- Assert rst after 12 bits of write 0x80 data 0x5555; release and send a full frame 0x81 data 0x0003 -> gpio_out=0x0003.
- Run sclk at clk/4 with random pin skew within one clk -> all of the above still pass.

Source files
------------

// File: rtl/spi_gpio_ctrl.sv
// SPI-slave (mode 0) GPIO controller: WIDTH pins with direction, atomic SET/CLR/TOGGLE
// and read-back over MISO. All SPI pins are oversampled on the system clock.
module spi_gpio_ctrl #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             frame_done
);

  localparam int CNT_W = $clog2(8 + WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(8 + WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(8 + WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_CMD  = CNT_W'(7);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic [CNT_W-1:0]       cnt;
  logic [7:0]             cmd;
  logic [WIDTH-1:0]       data, tx;
  logic                   tx_started;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic [7:0] cmd_next;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cmd_next  = {cmd[6:0], mosi_s};
  assign miso_oe   = ~cs_s;

  function automatic logic cmd_legal(input logic [7:0] c);
    if (c[7]) return (c[2:0] <= 3'd4);
    return (c[2:0] == 3'd0) || (c[2:0] == 3'd1) || (c[2:0] == 3'd4);
  endfunction

  // Equal-depth synchronisers keep mosi aligned with the sclk edge that samples it.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_next unassigned (no latch).
    state_next = state;
    unique case (state)
      IDLE: if (cs_fall) state_next = CMD;
      CMD: begin
        if (cs_rise)                            state_next = IDLE;
        else if (sclk_rise && cnt == CNT_CMD)   state_next = DATA;
      end
      DATA: if (cs_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_out   <= '0;
      gpio_oe    <= '0;
      miso       <= 1'b0;
      frame_done <= 1'b0;
      cnt        <= '0;
      cmd        <= '0;
      data       <= '0;
      tx         <= '0;
      tx_started <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state == IDLE) begin
        miso <= 1'b0;
        if (cs_fall) begin
          cnt        <= '0;
          cmd        <= '0;
          data       <= '0;
          tx_started <= 1'b0;
        end
      end else if (cs_rise) begin
        miso <= 1'b0;
        // Only an exact-length frame with a legal command has any effect.
        if (cnt == CNT_FULL && cmd_legal(cmd)) begin
          frame_done <= 1'b1;
          if (cmd[7]) begin
            unique case (cmd[2:0])
              3'd0:    gpio_out <= data;
              3'd1:    gpio_out <= gpio_out | data;
              3'd2:    gpio_out <= gpio_out & ~data;
              3'd3:    gpio_out <= gpio_out ^ data;
              default: gpio_oe  <= data;
            endcase
          end
        end
      end else begin
        if (sclk_rise) begin
          if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
          if (state == CMD) cmd  <= cmd_next;
          else              data <= {data[WIDTH-2:0], mosi_s};
          // Read value is captured in the same cycle the command byte completes.
          if (state == CMD && cnt == CNT_CMD && !cmd_next[7] && cmd_legal(cmd_next)) begin
            unique case (cmd_next[2:0])
              3'd1:    tx <= gpio_out;
              3'd4:    tx <= gpio_oe;
              default: tx <= gpio_in;
            endcase
          end
        end
        if (sclk_fall && state == DATA && !cmd[7] && cmd_legal(cmd)) begin
          if (!tx_started) begin
            miso       <= tx[WIDTH-1];
            tx_started <= 1'b1;
          end else begin
            miso <= tx[WIDTH-2];
            tx   <= {tx[WIDTH-2:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_gpio_ctrl.sv
// Directed bench for spi_gpio_ctrl (WIDTH=16): SPI master model at clk/4 with random
// per-bit skew on mosi and cs_n, frame_done pulse counting and MISO read-back.
module tb_spi_gpio_ctrl;
  localparam int WIDTH = 16;
  localparam int HALF  = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sclk = 1'b0;
  logic             cs_n = 1'b1;
  logic             mosi = 1'b0;
  logic             miso, miso_oe, frame_done;
  logic [WIDTH-1:0] gpio_in = '0;
  logic [WIDTH-1:0] gpio_out, gpio_oe;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   fd_count = 0;
  logic miso_samp [32];
  logic oe_samp   [32];

  spi_gpio_ctrl #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .gpio_oe(gpio_oe), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) fd_count++;

  task automatic cs_low();
    @(posedge clk);
    #($urandom_range(1, 7));
    cs_n = 1'b0;
    repeat (5) @(posedge clk);
    #2;
  endtask

  task automatic shift_bits(input logic [7:0] cmd, input logic [15:0] data,
                            input int first, input int last);
    logic [23:0] fr;
    int sk;
    fr = {cmd, data};
    for (int i = first; i <= last; i++) begin
      sk = $urandom_range(0, 7);
      #(sk);
      mosi = (i < 24) ? fr[23-i] : 1'b0;
      #(HALF - sk);
      sclk = 1'b1;
      #(HALF);
      miso_samp[i] = miso;
      oe_samp[i]   = miso_oe;
      sclk = 1'b0;
    end
  endtask

  task automatic cs_high();
    repeat (5) @(posedge clk);
    #($urandom_range(1, 7));
    cs_n = 1'b1;
    repeat (8) @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [15:0] data, input int nbits);
    cs_low();
    shift_bits(cmd, data, 0, nbits - 1);
    cs_high();
  endtask

  function automatic logic [15:0] rx_word();
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[15-i] = miso_samp[8+i];
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    n_cmp++; if (gpio_out !== 16'h0000) begin n_bad++; $display("FAIL reset_out: got %h want 0000", gpio_out); end
    n_cmp++; if (gpio_oe !== 16'h0000) begin n_bad++; $display("FAIL reset_oe: got %h want 0000", gpio_oe); end
    n_cmp++; if (miso !== 1'b0) begin n_bad++; $display("FAIL reset_miso: got %b want 0", miso); end
    n_cmp++; if (miso_oe !== 1'b0) begin n_bad++; $display("FAIL reset_miso_oe: got %b want 0", miso_oe); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic test_write();
    int fd0;
    fd0 = fd_count;
    send_frame(8'h80, 16'hA5C3, 24);
    n_cmp++; if (gpio_out !== 16'hA5C3) begin n_bad++; $display("FAIL write_out: got %h want a5c3", gpio_out); end
    n_cmp++; if (gpio_oe !== 16'h0000) begin n_bad++; $display("FAIL write_oe: got %h want 0000", gpio_oe); end
    n_cmp++; if (fd_count - fd0 !== 1) begin n_bad++; $display("FAIL write_frame_done: got %0d pulses want 1", fd_count - fd0); end
  endtask

  task automatic test_set_clr_tgl();
    logic [7:0]  cmds [4] = '{8'h80, 8'h81, 8'h82, 8'h83};
    logic [15:0] dats [4] = '{16'h00F0, 16'h0F00, 16'h0030, 16'h8001};
    logic [15:0] exps [4] = '{16'h00F0, 16'h0FF0, 16'h0FC0, 16'h8FC1};
    int fd0;
    for (int i = 0; i < 4; i++) begin
      fd0 = fd_count;
      send_frame(cmds[i], dats[i], 24);
      n_cmp++; if (gpio_out !== exps[i]) begin n_bad++; $display("FAIL atomic_out[%0d]: got %h want %h", i, gpio_out, exps[i]); end
      n_cmp++; if (fd_count - fd0 !== 1) begin n_bad++; $display("FAIL atomic_frame_done[%0d]: got %0d want 1", i, fd_count - fd0); end
    end
  endtask

  task automatic test_read();
    logic [7:0]  cmds [3] = '{8'h04, 8'h00, 8'h01};
    logic [15:0] exps [3] = '{16'hFFFF, 16'h1234, 16'h8FC1};
    int fd0;
    send_frame(8'h84, 16'hFFFF, 24);
    n_cmp++; if (gpio_oe !== 16'hFFFF) begin n_bad++; $display("FAIL read_setup_oe: got %h want ffff", gpio_oe); end
    gpio_in = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      fd0 = fd_count;
      send_frame(cmds[i], 16'h0000, 24);
      n_cmp++; if (rx_word() !== exps[i]) begin n_bad++; $display("FAIL read_miso[%0d]: got %h want %h", i, rx_word(), exps[i]); end
      n_cmp++; if (miso_samp[4] !== 1'b0) begin n_bad++; $display("FAIL read_miso_in_cmd[%0d]: got %b want 0", i, miso_samp[4]); end
      n_cmp++; if (oe_samp[10] !== 1'b1) begin n_bad++; $display("FAIL read_miso_oe_in_frame[%0d]: got %b want 1", i, oe_samp[10]); end
      n_cmp++; if (miso_oe !== 1'b0) begin n_bad++; $display("FAIL read_miso_oe_idle[%0d]: got %b want 0", i, miso_oe); end
      n_cmp++; if (miso !== 1'b0) begin n_bad++; $display("FAIL read_miso_idle[%0d]: got %b want 0", i, miso); end
      n_cmp++; if (fd_count - fd0 !== 1) begin n_bad++; $display("FAIL read_frame_done[%0d]: got %0d want 1", i, fd_count - fd0); end
    end
    n_cmp++; if (gpio_out !== 16'h8FC1) begin n_bad++; $display("FAIL read_out_unchanged: got %h want 8fc1", gpio_out); end
    n_cmp++; if (gpio_oe !== 16'hFFFF) begin n_bad++; $display("FAIL read_oe_unchanged: got %h want ffff", gpio_oe); end
  endtask

  task automatic test_bad_frames();
    logic [7:0] cmds [4] = '{8'h80, 8'h80, 8'h87, 8'h02};
    int         bits [4] = '{23, 25, 24, 24};
    int fd0;
    for (int i = 0; i < 4; i++) begin
      fd0 = fd_count;
      send_frame(cmds[i], 16'hBEEF, bits[i]);
      n_cmp++; if (gpio_out !== 16'h8FC1) begin n_bad++; $display("FAIL bad_out[%0d]: got %h want 8fc1", i, gpio_out); end
      n_cmp++; if (gpio_oe !== 16'hFFFF) begin n_bad++; $display("FAIL bad_oe[%0d]: got %h want ffff", i, gpio_oe); end
      n_cmp++; if (fd_count - fd0 !== 0) begin n_bad++; $display("FAIL bad_frame_done[%0d]: got %0d want 0", i, fd_count - fd0); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int fd0;
    fd0 = fd_count;
    cs_low();
    shift_bits(8'h80, 16'h5555, 0, 11);
    @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    n_cmp++; if (gpio_out !== 16'h0000) begin n_bad++; $display("FAIL midrst_out: got %h want 0000", gpio_out); end
    n_cmp++; if (gpio_oe !== 16'h0000) begin n_bad++; $display("FAIL midrst_oe: got %h want 0000", gpio_oe); end
    n_cmp++; if (miso_oe !== 1'b0) begin n_bad++; $display("FAIL midrst_miso_oe: got %b want 0", miso_oe); end
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    shift_bits(8'h80, 16'h5555, 12, 23);
    cs_high();
    n_cmp++; if (gpio_out !== 16'h0000) begin n_bad++; $display("FAIL midrst_tail_out: got %h want 0000", gpio_out); end
    n_cmp++; if (fd_count - fd0 !== 0) begin n_bad++; $display("FAIL midrst_tail_frame_done: got %0d want 0", fd_count - fd0); end
    fd0 = fd_count;
    send_frame(8'h81, 16'h0003, 24);
    n_cmp++; if (gpio_out !== 16'h0003) begin n_bad++; $display("FAIL midrst_next_out: got %h want 0003", gpio_out); end
    n_cmp++; if (fd_count - fd0 !== 1) begin n_bad++; $display("FAIL midrst_next_frame_done: got %0d want 1", fd_count - fd0); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_set_clr_tgl();
    test_read();
    test_bad_frames();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
